// File: rtl/tictactoe_input_ctrl.sv
// tictactoe_input_ctrl
//   Input conditioning for the TicTacToe game FSM. Seven raw pushbuttons are
//   each synchronized (2 FF), debounced (down to a stable level after
//   DEBOUNCE_CYCLES consecutive differing samples) and rising-edge detected.
//   The press events drive a 3x3 wrap-around cursor and the one-cycle
//   cuadro / erase / restart pulses consumed by the game FSM.
//
// Ports
//   clk_100MHz   system clock, rising edge
//   reset        synchronous, active-low reset
//   btn_up/down/left/right/sel/erase/restart   raw async buttons, active-high
//   cuadro       one-hot one-cycle selection pulse, row-major square index
//   erase        one-cycle erase pulse
//   restart      one-cycle restart pulse
//   cursor       one-hot current cursor square (level)
//   cursor_idx   binary cursor index 0..8
module tictactoe_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_erase,
  input  logic       btn_restart,
  output logic [8:0] cuadro,
  output logic       erase,
  output logic       restart,
  output logic [8:0] cursor,
  output logic [3:0] cursor_idx
);

  localparam int UP      = 0;
  localparam int DOWN    = 1;
  localparam int LEFT    = 2;
  localparam int RIGHT   = 3;
  localparam int SEL     = 4;
  localparam int ERASE   = 5;
  localparam int RESTART = 6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       IDX_CENTRE = 4'd4;

  logic [6:0]       raw;
  logic [6:0]       sync1;
  logic [6:0]       sync2;
  logic [6:0]       deb;
  logic [6:0]       deb_prev;
  logic [6:0]       evt;
  logic [6:0]       press;
  logic [CNT_W-1:0] cnt [7];

  logic [1:0]       row;
  logic [1:0]       col;
  logic [1:0]       row_n;
  logic [1:0]       col_n;
  logic [3:0]       next_idx;

  assign raw = {btn_restart, btn_erase, btn_sel, btn_right, btn_left, btn_down, btn_up};

  // Rising edge of the debounced level; registered into press below.
  assign evt = deb & ~deb_prev;

  // Cursor movement driven by the previous cycle's press events. next_idx is
  // also the cursor as seen by a selection in the current cycle, so a move
  // and a select arriving together always mark the pre-move square.
  always_comb begin
    row = 2'd0;
    if (cursor_idx >= 4'd6)
      row = 2'd2;
    else if (cursor_idx >= 4'd3)
      row = 2'd1;
    col = 2'(cursor_idx - 4'd3 * {2'b00, row});

    row_n = row;
    if (press[UP] && !press[DOWN])
      row_n = (row == 2'd0) ? 2'd2 : row - 2'd1;
    else if (press[DOWN] && !press[UP])
      row_n = (row == 2'd2) ? 2'd0 : row + 2'd1;

    col_n = col;
    if (press[LEFT] && !press[RIGHT])
      col_n = (col == 2'd0) ? 2'd2 : col - 2'd1;
    else if (press[RIGHT] && !press[LEFT])
      col_n = (col == 2'd2) ? 2'd0 : col + 2'd1;

    if (press[RESTART])
      next_idx = IDX_CENTRE;
    else
      next_idx = 4'd3 * {2'b00, row_n} + {2'b00, col_n};
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      deb_prev   <= '0;
      press      <= '0;
      for (int i = 0; i < 7; i++)
        cnt[i] <= '0;
      cuadro     <= '0;
      cursor_idx <= IDX_CENTRE;
      cursor     <= 9'b000010000;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= evt;

      // Any sample agreeing with the current level restarts the count, so
      // only an uninterrupted run of DEBOUNCE_CYCLES differing samples flips it.
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end

      // Restart wins over a simultaneous selection.
      if (evt[SEL] && !evt[RESTART])
        cuadro <= 9'(1) << next_idx;
      else
        cuadro <= '0;

      cursor_idx <= next_idx;
      cursor     <= 9'(1) << next_idx;
    end
  end

  assign erase   = press[ERASE];
  assign restart = press[RESTART];

endmodule

// File: tb/tb_tictactoe_input_ctrl.sv
// Directed testbench for tictactoe_input_ctrl with DEBOUNCE_CYCLES = 4.
module tb_tictactoe_input_ctrl;

  localparam int DB = 4;

  // Button mask bit positions used by the stimulus tasks.
  localparam int B_UP      = 0;
  localparam int B_DOWN    = 1;
  localparam int B_LEFT    = 2;
  localparam int B_RIGHT   = 3;
  localparam int B_SEL     = 4;
  localparam int B_ERASE   = 5;
  localparam int B_RESTART = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_sel = 1'b0, btn_erase = 1'b0, btn_restart = 1'b0;
  logic [8:0] cuadro;
  logic       erase;
  logic       restart;
  logic [8:0] cursor;
  logic [3:0] cursor_idx;

  int checks = 0;
  int errors = 0;

  int         n_cuadro;
  int         n_erase;
  int         n_restart;
  logic [8:0] last_cuadro;
  logic       erase_with_sel;

  tictactoe_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(24)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_sel    (btn_sel),
    .btn_erase  (btn_erase),
    .btn_restart(btn_restart),
    .cuadro     (cuadro),
    .erase      (erase),
    .restart    (restart),
    .cursor     (cursor),
    .cursor_idx (cursor_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btns(input logic [6:0] m);
    btn_up      = m[B_UP];
    btn_down    = m[B_DOWN];
    btn_left    = m[B_LEFT];
    btn_right   = m[B_RIGHT];
    btn_sel     = m[B_SEL];
    btn_erase   = m[B_ERASE];
    btn_restart = m[B_RESTART];
  endtask

  task automatic sample();
    if (cuadro != 9'd0) begin
      n_cuadro++;
      last_cuadro = cuadro;
      if (erase) erase_with_sel = 1'b1;
    end
    if (erase)   n_erase++;
    if (restart) n_restart++;
  endtask

  // Hold the buttons in mask m long enough to debounce, release, let the
  // release debounce too, and tally every output pulse seen meanwhile.
  task automatic press(input logic [6:0] m);
    n_cuadro = 0; n_erase = 0; n_restart = 0;
    last_cuadro = '0; erase_with_sel = 1'b0;
    @(negedge clk);
    set_btns(m);
    repeat (16) begin @(negedge clk); sample(); end
    set_btns(7'd0);
    repeat (12) begin @(negedge clk); sample(); end
  endtask

  initial begin
    // 1: reset state
    set_btns(7'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idx", 32'(cursor_idx), 32'd4);
    check("rst_cursor", 32'(cursor), 32'h010);
    check("rst_cuadro", 32'(cuadro), 32'h0);
    check("rst_erase", 32'(erase), 32'd0);
    check("rst_restart", 32'(restart), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 2: sel held -> single pulse exactly DB+3 edges later
    btn_sel = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check($sformatf("sel_lat_e%0d", j), 32'(cuadro), (j == DB + 3) ? 32'h010 : 32'h0);
    end
    btn_sel = 1'b0;
    repeat (12) @(negedge clk);
    check("sel_release", 32'(cuadro), 32'h0);

    // 3: bounce shorter than DB never produces a pulse
    n_cuadro = 0;
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < 4; b++) begin
        btn_sel = (b < 3);
        @(negedge clk);
        sample();
      end
    end
    repeat (6) begin @(negedge clk); sample(); end
    check("bounce_no_pulse", 32'(n_cuadro), 32'd0);
    btn_sel = 1'b1;
    repeat (10) begin @(negedge clk); sample(); end
    btn_sel = 1'b0;
    repeat (12) begin @(negedge clk); sample(); end
    check("bounce_then_hold", 32'(n_cuadro), 32'd1);

    // 4: single moves with wraps
    press(7'(1 << B_RIGHT));
    check("mv_right_idx", 32'(cursor_idx), 32'd5);
    check("mv_right_cur", 32'(cursor), 32'h020);
    press(7'(1 << B_RIGHT));
    check("mv_right_wrap_idx", 32'(cursor_idx), 32'd3);
    check("mv_right_wrap_cur", 32'(cursor), 32'h008);
    press(7'(1 << B_DOWN));
    check("mv_down_idx", 32'(cursor_idx), 32'd6);
    check("mv_down_cur", 32'(cursor), 32'h040);
    press(7'(1 << B_DOWN));
    check("mv_down_wrap_idx", 32'(cursor_idx), 32'd0);
    check("mv_down_wrap_cur", 32'(cursor), 32'h001);
    press(7'(1 << B_LEFT));
    check("mv_left_wrap_idx", 32'(cursor_idx), 32'd2);
    check("mv_left_wrap_cur", 32'(cursor), 32'h004);
    check("mv_no_cuadro", 32'(n_cuadro), 32'd0);

    // 5: back to 0, then diagonal and cancel
    press(7'(1 << B_LEFT));
    press(7'(1 << B_LEFT));
    check("mv_to0_idx", 32'(cursor_idx), 32'd0);
    press(7'((1 << B_UP) | (1 << B_LEFT)));
    check("diag_idx", 32'(cursor_idx), 32'd8);
    check("diag_cur", 32'(cursor), 32'h100);
    press(7'((1 << B_UP) | (1 << B_DOWN)));
    check("cancel_idx", 32'(cursor_idx), 32'd8);
    press(7'((1 << B_LEFT) | (1 << B_RIGHT)));
    check("cancel_lr_idx", 32'(cursor_idx), 32'd8);

    // 6: restart beats sel; erase and sel coincide
    press(7'((1 << B_SEL) | (1 << B_RESTART)));
    check("rs_restart_cnt", 32'(n_restart), 32'd1);
    check("rs_cuadro_cnt", 32'(n_cuadro), 32'd0);
    check("rs_idx", 32'(cursor_idx), 32'd4);
    check("rs_cur", 32'(cursor), 32'h010);
    press(7'((1 << B_SEL) | (1 << B_ERASE)));
    check("es_erase_cnt", 32'(n_erase), 32'd1);
    check("es_cuadro_cnt", 32'(n_cuadro), 32'd1);
    check("es_cuadro_val", 32'(last_cuadro), 32'h010);
    check("es_same_cycle", 32'(erase_with_sel), 32'd1);
    check("es_restart_cnt", 32'(n_restart), 32'd0);

    // sel at a corner reports that square
    press(7'((1 << B_UP) | (1 << B_RIGHT)));
    check("corner_idx", 32'(cursor_idx), 32'd2);
    press(7'(1 << B_SEL));
    check("corner_sel", 32'(last_cuadro), 32'h004);
    check("corner_sel_cnt", 32'(n_cuadro), 32'd1);

    // restart pulse alone recentres
    press(7'(1 << B_RESTART));
    check("restart_alone_idx", 32'(cursor_idx), 32'd4);
    check("restart_alone_cnt", 32'(n_restart), 32'd1);

    // Reset mid-debounce with button held: re-debounce from scratch
    @(negedge clk);
    btn_sel = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_cuadro", 32'(cuadro), 32'h0);
    check("midrst_idx", 32'(cursor_idx), 32'd4);
    reset = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check($sformatf("midrst_lat_e%0d", j), 32'(cuadro), (j == DB + 3) ? 32'h010 : 32'h0);
    end
    btn_sel = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
